// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter: FSM and owner
// encodings, counter width and the default memory latency (also used by
// memory models that sit behind the arbiter).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int CNT_W           = 4;

  // A latency is usable when it is non-zero and fits the down-counter.
  function automatic bit lat_legal(input int lat);
    return (lat >= 1) && (lat <= (2 ** CNT_W) - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of everything the arbiter exchanges with the pipeline and the
// single-port memory. The arbiter uses the slave modport; the pipeline /
// memory side (or a testbench) uses the master modport.
//
// Handshake: a requester raises *_req with a stable address (and store
// data) and keeps it high until the matching *_ready pulse, which lasts
// exactly one cycle and coincides with valid *_rdata. An IF request may
// also be withdrawn by if_flush. mem_en is a single-cycle strobe per
// access; mem_addr / mem_wdata stay stable until the access finishes.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // instruction-fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;

  // data-memory side
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  // memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // pipeline control and observability
  logic              stall_if;
  logic              stall_mem;
  logic              busy;
  arb_state_e        dbg_state;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_ready, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ready, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_if, stall_mem, busy, dbg_state
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_ready, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ready, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_if, stall_mem, busy, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times the fixed memory latency. It saturates
// at zero so an extra enable cycle can never wrap it around.
module lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // load has priority over decrement; reset returns to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one
// single-port synchronous memory. Data accesses win ties because they
// belong to the older instruction. Each access runs IDLE -> BUSY (latency
// wait) -> DONE (ready pulse), and the arbiter produces the freeze signals
// that stall the front end or the whole pipeline while a port waits.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  // A zero latency would leave no cycle for mem_en before the capture,
  // and anything above 15 does not fit the counter.
  if (!lat_legal(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

  arb_state_e        state_q, state_nxt;
  owner_e            owner_q;
  logic              cancel_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic              cnt_load;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  logic              grant_mem;
  logic              grant_if;
  logic              first_busy;
  logic              capture;

  // Grants only happen in IDLE; a fetch that is being flushed is not started.
  assign grant_mem  = (state_q == IDLE) && bus.dm_req;
  assign grant_if   = (state_q == IDLE) && !bus.dm_req && bus.if_req && !bus.if_flush;
  // The counter still holds its load value only in the first BUSY cycle.
  assign first_busy = (state_q == BUSY) && (cnt == LAT_LOAD);
  // Last BUSY cycle: mem_rdata is valid now.
  assign capture    = (state_q == BUSY) && cnt_zero;

  lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LAT_LOAD),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next-state and counter control
  always_comb begin
    state_nxt = state_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_mem || grant_if) begin
          cnt_load  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the granted request and remember who owns the access
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant_mem) begin
      owner_q     <= OWN_MEM;
      mem_we_q    <= bus.dm_we;
      mem_addr_q  <= bus.dm_addr;
      mem_wdata_q <= bus.dm_wdata;
    end else if (grant_if) begin
      owner_q     <= OWN_IF;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= bus.if_addr;
      mem_wdata_q <= '0;
    end else if (state_q == DONE) begin
      owner_q     <= OWN_NONE;
    end
  end

  // A flush during a fetch marks the access as cancelled until DONE ends
  always_ff @(posedge clk) begin
    if (rst) begin
      cancel_q <= 1'b0;
    end else if (state_q == DONE) begin
      cancel_q <= 1'b0;
    end else if ((state_q == BUSY) && (owner_q == OWN_IF) && bus.if_flush) begin
      cancel_q <= 1'b1;
    end
  end

  // Capture read data into the owner's register; stores and cancelled
  // fetches leave the registers untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (capture) begin
      if ((owner_q == OWN_MEM) && !mem_we_q) begin
        dm_rdata_q <= bus.mem_rdata;
      end
      if ((owner_q == OWN_IF) && !cancel_q && !bus.if_flush) begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Outputs: memory strobes, ready pulses and pipeline freezes
  always_comb begin
    bus.mem_en    = first_busy;
    bus.mem_we    = first_busy && mem_we_q;
    bus.mem_addr  = mem_addr_q;
    bus.mem_wdata = mem_wdata_q;
    bus.if_ready  = (state_q == DONE) && (owner_q == OWN_IF) && !cancel_q;
    bus.dm_ready  = (state_q == DONE) && (owner_q == OWN_MEM);
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
    bus.stall_if  = bus.if_req && !bus.if_ready;
    bus.stall_mem = bus.dm_req && !bus.dm_ready;
    bus.busy      = (state_q != IDLE);
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at the default latency
// (2) and one at latency 1, each with a small timed memory model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  // memory contents seen by reads
  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2008_0005;
      32'h0000_0100: return 32'hDEAD_BEEF;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // timed memory models: read data valid exactly LAT cycles after mem_en,
  // a junk pattern at every other time
  logic        p0, p1;
  logic [3:0]  c0, c1;
  logic [31:0] d0, d1;

  always @(posedge clk) begin
    if (rst) begin
      p0 <= 1'b0;
    end else if (b0.mem_en && !b0.mem_we) begin
      p0 <= 1'b1; c0 <= 4'd1; d0 <= mem_lookup(b0.mem_addr);
    end else if (p0) begin
      if (c0 == 4'd0) p0 <= 1'b0; else c0 <= c0 - 4'd1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      p1 <= 1'b0;
    end else if (b1.mem_en && !b1.mem_we) begin
      p1 <= 1'b1; c1 <= 4'd0; d1 <= mem_lookup(b1.mem_addr);
    end else if (p1) begin
      if (c1 == 4'd0) p1 <= 1'b0; else c1 <= c1 - 4'd1;
    end
  end

  assign b0.mem_rdata = (p0 && (c0 == 4'd0)) ? d0 : 32'hBAD0_BAD0;
  assign b1.mem_rdata = (p1 && (c1 == 4'd0)) ? d1 : 32'hBAD0_BAD0;

  // driver helpers
  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    b0.if_req = 0; b0.if_addr = 0; b0.if_flush = 0;
    b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = 0; b0.dm_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.if_flush = 0;
    b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;

    // reset state
    go(3);
    chk("rst_state",  b0.dbg_state, IDLE);
    chk("rst_mem_en", b0.mem_en, 0);
    chk("rst_addr",   b0.mem_addr, 0);
    chk("rst_ifrd",   b0.if_rdata, 0);
    chk("rst_dmrd",   b0.dm_rdata, 0);
    chk("rst_busy",   b0.busy, 0);
    chk("rst_busy1",  b1.busy, 0);
    rst = 0;
    go(1);

    // IF only
    b0.if_req = 1; b0.if_addr = 32'h40; #1;
    chk("if_stall_T", b0.stall_if, 1);
    chk("if_busy_T",  b0.busy, 0);
    go(1);
    chk("if_en_T1",    b0.mem_en, 1);
    chk("if_we_T1",    b0.mem_we, 0);
    chk("if_addr_T1",  b0.mem_addr, 32'h40);
    chk("if_state_T1", b0.dbg_state, BUSY);
    go(1);
    chk("if_en_T2",   b0.mem_en, 0);
    chk("if_addr_T2", b0.mem_addr, 32'h40);
    go(1);
    chk("if_rdy_T3",   b0.if_ready, 0);
    chk("if_stall_T3", b0.stall_if, 1);
    go(1);
    chk("if_rdy_T4",   b0.if_ready, 1);
    chk("if_rdata_T4", b0.if_rdata, 32'h2008_0005);
    chk("if_stall_T4", b0.stall_if, 0);
    chk("if_state_T4", b0.dbg_state, DONE);
    go(1);
    b0.if_req = 0; #1;
    chk("if_rdy_T5",  b0.if_ready, 0);
    chk("if_busy_T5", b0.busy, 0);
    go(1);

    // simultaneous IF and load: load first
    b0.if_req = 1; b0.if_addr = 32'h80;
    b0.dm_req = 1; b0.dm_we = 0; b0.dm_addr = 32'h100; #1;
    chk("sim_stallif_T",  b0.stall_if, 1);
    chk("sim_stallmem_T", b0.stall_mem, 1);
    go(1);
    chk("sim_en_T1",   b0.mem_en, 1);
    chk("sim_addr_T1", b0.mem_addr, 32'h100);
    go(3);
    chk("sim_dmrdy_T4",    b0.dm_ready, 1);
    chk("sim_dmrd_T4",     b0.dm_rdata, 32'hDEAD_BEEF);
    chk("sim_ifrdy_T4",    b0.if_ready, 0);
    chk("sim_stallif_T4",  b0.stall_if, 1);
    chk("sim_stallmem_T4", b0.stall_mem, 0);
    go(1);
    b0.dm_req = 0; #1;
    chk("sim_busy_T5",    b0.busy, 0);
    chk("sim_stallif_T5", b0.stall_if, 1);
    chk("sim_dmrdy_T5",   b0.dm_ready, 0);
    go(1);
    chk("sim_en_T6",   b0.mem_en, 1);
    chk("sim_addr_T6", b0.mem_addr, 32'h80);
    go(3);
    chk("sim_ifrdy_T9", b0.if_ready, 1);
    chk("sim_ifrd_T9",  b0.if_rdata, 32'hA5A5_0080);
    go(1);
    b0.if_req = 0; #1;
    chk("sim_busy_T10", b0.busy, 0);
    go(1);

    // store
    b0.dm_req = 1; b0.dm_we = 1; b0.dm_addr = 32'h200; b0.dm_wdata = 32'h1234_5678; #1;
    go(1);
    chk("st_en_T1",    b0.mem_en, 1);
    chk("st_we_T1",    b0.mem_we, 1);
    chk("st_addr_T1",  b0.mem_addr, 32'h200);
    chk("st_wdata_T1", b0.mem_wdata, 32'h1234_5678);
    go(1);
    chk("st_en_T2",    b0.mem_en, 0);
    chk("st_we_T2",    b0.mem_we, 0);
    chk("st_wdata_T2", b0.mem_wdata, 32'h1234_5678);
    go(1);
    chk("st_wdata_T3", b0.mem_wdata, 32'h1234_5678);
    go(1);
    chk("st_rdy_T4",  b0.dm_ready, 1);
    chk("st_dmrd_T4", b0.dm_rdata, 32'hDEAD_BEEF);
    go(1);
    b0.dm_req = 0; b0.dm_we = 0; #1;
    chk("st_dmrd_T5", b0.dm_rdata, 32'hDEAD_BEEF);
    go(1);

    // flush during a fetch
    b0.if_req = 1; b0.if_addr = 32'h44; #1;
    go(1);
    chk("fl_en_T1",   b0.mem_en, 1);
    chk("fl_addr_T1", b0.mem_addr, 32'h44);
    go(1);
    b0.if_flush = 1; #1;
    chk("fl_busy_T2", b0.busy, 1);
    go(1);
    b0.if_flush = 0; b0.if_req = 0; #1;
    go(1);
    chk("fl_rdy_T4",  b0.if_ready, 0);
    chk("fl_ifrd_T4", b0.if_rdata, 32'hA5A5_0080);
    chk("fl_busy_T4", b0.busy, 1);
    go(1);
    chk("fl_busy_T5", b0.busy, 0);
    b0.if_req = 1; b0.if_addr = 32'h48; #1;
    go(1);
    chk("fl_en_T6",   b0.mem_en, 1);
    chk("fl_addr_T6", b0.mem_addr, 32'h48);
    go(3);
    chk("fl_rdy_T9",  b0.if_ready, 1);
    chk("fl_ifrd_T9", b0.if_rdata, 32'hA5A5_0048);
    go(1);
    b0.if_req = 0; #1;
    go(1);

    // fetch with flush in IDLE: no grant
    b0.if_req = 1; b0.if_flush = 1; #1;
    go(1);
    chk("idlefl_busy", b0.busy, 0);
    chk("idlefl_en",   b0.mem_en, 0);
    b0.if_req = 0; b0.if_flush = 0; #1;
    go(1);

    // reset in the middle of a load
    b0.dm_req = 1; b0.dm_we = 0; b0.dm_addr = 32'h104; #1;
    go(1);
    chk("rs_en_T1", b0.mem_en, 1);
    go(1);
    rst = 1; b0.dm_req = 0; #1;
    go(1);
    rst = 0; #1;
    chk("rs_state_T3", b0.dbg_state, IDLE);
    chk("rs_en_T3",    b0.mem_en, 0);
    chk("rs_we_T3",    b0.mem_we, 0);
    chk("rs_addr_T3",  b0.mem_addr, 0);
    chk("rs_wdata_T3", b0.mem_wdata, 0);
    chk("rs_ifrdy_T3", b0.if_ready, 0);
    chk("rs_dmrdy_T3", b0.dm_ready, 0);
    chk("rs_ifrd_T3",  b0.if_rdata, 0);
    chk("rs_dmrd_T3",  b0.dm_rdata, 0);
    chk("rs_stif_T3",  b0.stall_if, 0);
    chk("rs_stmem_T3", b0.stall_mem, 0);
    chk("rs_busy_T3",  b0.busy, 0);
    go(1);
    chk("rs_dmrdy_T4", b0.dm_ready, 0);
    b0.dm_req = 1; b0.dm_addr = 32'h100; #1;
    go(4);
    chk("rs_new_rdy",  b0.dm_ready, 1);
    chk("rs_new_dmrd", b0.dm_rdata, 32'hDEAD_BEEF);
    go(1);
    b0.dm_req = 0; #1;
    go(1);

    // latency-1 build: fetch
    b1.if_req = 1; b1.if_addr = 32'h40; #1;
    go(1);
    chk("l1_if_en_T1", b1.mem_en, 1);
    go(1);
    chk("l1_if_rdy_T2", b1.if_ready, 0);
    go(1);
    chk("l1_if_rdy_T3", b1.if_ready, 1);
    chk("l1_if_rd_T3",  b1.if_rdata, 32'h2008_0005);
    go(1);
    b1.if_req = 0; #1;
    chk("l1_if_busy_T4", b1.busy, 0);
    go(1);

    // latency-1 build: four loads back to back, one every 4 cycles
    for (int i = 0; i < 4; i++) begin
      b1.dm_req = 1; b1.dm_we = 0; b1.dm_addr = 32'h300 + 32'(4 * i); #1;
      chk("l1_lw_idle", b1.busy, 0);
      go(1);
      chk("l1_lw_en",   b1.mem_en, 1);
      chk("l1_lw_addr", b1.mem_addr, 32'h300 + 32'(4 * i));
      go(1);
      chk("l1_lw_rdy0", b1.dm_ready, 0);
      go(1);
      chk("l1_lw_rdy1", b1.dm_ready, 1);
      chk("l1_lw_data", b1.dm_rdata, 32'hA5A5_0000 ^ (32'h300 + 32'(4 * i)));
      go(1);
    end
    b1.dm_req = 0; #1;
    chk("l1_end_busy", b1.busy, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch stage (IF) and the data-memory stage (MEM, lw/sw).
- Serialises accesses through a small FSM with a fixed-latency wait counter.
- Returns one-cycle ready pulses and generates the pipeline freeze signals that sit alongside the decoder's load-use stall.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, number of cycles from the memory-enable cycle to the cycle in which mem_rdata is valid. Legal values are 1 to 15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request, held until if_ready or if_flush.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  branch/jump redirect; cancels the current fetch.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched instruction, registered.
- dm_req  in  1  data request, held until dm_ready.
- dm_we  in  1  1 = store (sw), 0 = load (lw).
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_ready  out  1  one-cycle data completion pulse.
- dm_rdata  out  DATA_W  load data, registered.
- mem_en  out  1  memory enable, one pulse per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address, held for the whole access.
- mem_wdata  out  DATA_W  memory write data, held for the whole access.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  freezes PC and IF/ID.
- stall_mem  out  1  freezes the entire pipeline.
- busy  out  1  an access is in flight.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst).
- Reset state: FSM in IDLE, counter 0, current owner = none, cancel flag cleared. All outputs are 0, including if_rdata and dm_rdata.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If dm_req is high, grant MEM: data has fixed priority because it is the older instruction.
  - Otherwise, if if_req is high and if_flush is low, grant IF.
  - On a grant: latch addr, we and wdata into the mem_* registers, load the counter with MEM_LAT, record the owner, and go to BUSY.
  - if_req together with if_flush in IDLE produces no grant.
- BUSY:
  - mem_en = 1 in the first BUSY cycle only. mem_we equals the latched dm_we in that cycle; it is 0 for fetches.
  - mem_addr and mem_wdata are stable for the whole of BUSY.
  - The counter decrements each cycle. When it reaches 0, mem_rdata is captured into the owner's rdata register (loads and fetches only) and the FSM goes to DONE.
  - BUSY lasts MEM_LAT+1 cycles.
- DONE:
  - The owner's ready pulses for exactly one cycle. No new request is accepted in this cycle. Next state is IDLE.
- Latency: request sampled in IDLE at cycle T gives mem_en at T+1 and ready at T+MEM_LAT+2. With MEM_LAT=2, ready is at T+4 and back-to-back accesses take 5 cycles each.
- Stores: dm_ready pulses, dm_rdata is unchanged, and mem_rdata is ignored.
- if_flush while an IF access is in BUSY:
  - Set the cancel flag.
  - The memory access still completes.
  - if_rdata is not updated and if_ready is suppressed in DONE.
  - The flag clears on leaving DONE.
- if_flush during a MEM-owned access has no effect.
- stall_if = if_req & ~if_ready. stall_mem = dm_req & ~dm_ready. busy = (state != IDLE). All three are combinational from registered state and the inputs.
- A request dropped mid-access (protocol violation) does not abort the access; the ready pulse is still generated.
- rst asserted in any state aborts the in-flight access with no ready pulse. All outputs are 0 in the next cycle.
- Width rule: the counter is 4 bits. MEM_LAT=0 is illegal and is flagged by an elaboration-time check.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the owner encoding (OWN_NONE, OWN_IF, OWN_MEM);
  - the MEM_LAT default, shared with the memory model.
- One natural sub-module, lat_counter: loadable 4-bit down-counter with load, enable and zero outputs.
- The FSM, latches and stall logic stay in mem_port_arbiter.

Test Plan:
- IF only: if_req=1, if_addr=0x0000_0040, memory returns 0x2008_0005 -> mem_en at T+1 with mem_addr=0x40, if_ready one cycle at T+4, if_rdata=0x2008_0005, stall_if high for T..T+3.
- Simultaneous: if_req and dm_req (lw, 0x100 -> 0xDEAD_BEEF) both at T -> MEM served first with dm_ready at T+4; IF granted from IDLE at T+5 with if_ready at T+9; stall_if held throughout.
- Store: dm_req=1, dm_we=1, addr 0x200, wdata 0x1234_5678 -> mem_we=mem_en=1 at T+1 only, mem_wdata stable T+1..T+3, dm_ready at T+4, dm_rdata unchanged.
- Flush: IF access in flight, if_flush pulsed at T+2 -> no if_ready, if_rdata keeps its old value, busy drops at T+5, a new fetch is accepted at T+5.
- Reset mid-access: rst at T+2 of a lw -> no dm_ready, all outputs 0 at T+3, FSM in IDLE; a new request is served normally afterwards.
- MEM_LAT=1 build: any request -> ready at T+3; four consecutive lw requests complete at 4-cycle spacing.
